// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values and the fetch sequencer state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_LDA  = 4'b0000;
  localparam logic [3:0] OP_LDB  = 4'b0001;
  localparam logic [3:0] OP_LDO  = 4'b0010;
  localparam logic [3:0] OP_LDSA = 4'b0011;
  localparam logic [3:0] OP_LDSB = 4'b0100;
  localparam logic [3:0] OP_LSH  = 4'b0101;
  localparam logic [3:0] OP_RSH  = 4'b0110;
  localparam logic [3:0] OP_CLR  = 4'b0111;
  localparam logic [3:0] OP_SNZA = 4'b1000;
  localparam logic [3:0] OP_SNZS = 4'b1001;
  // CLR doubles as the no-op the execute stage sees after reset or a flush
  localparam logic [3:0] OP_NOP  = OP_CLR;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the program-memory bus and the fetch-to-execute valid/ready handshake.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 4
);

  logic [ADDR_WIDTH-1:0]  addressOut;
  logic [INSTR_WIDTH-1:0] dataIn;
  logic [INSTR_WIDTH-1:0] instrOut;
  logic                   instrValid;
  logic                   instrReady;
  logic                   skipReq;
  logic                   progWrap;

  modport master (
    output addressOut, instrOut, instrValid, progWrap,
    input  dataIn, instrReady, skipReq
  );

  modport slave (
    input  addressOut, instrOut, instrValid, progWrap,
    output dataIn, instrReady, skipReq
  );

endinterface

// File: rtl/instr_fetch_pc_counter.sv
// Program counter with synchronous clear, increment with PROG_LEN wrap, and a
// registered pulse flagging the cycle after a wrapping update.
module pc_counter #(
  parameter int ADDR_WIDTH = 8,
  parameter int PROG_LEN   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  wrap
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_LEN - 1);

  logic atLast;

  assign atLast = (pc == LAST_ADDR);

  // A clear never reports a wrap, so restart cannot be mistaken for program end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= '0;
      wrap <= 1'b0;
    end else if (clear) begin
      pc   <= '0;
      wrap <= 1'b0;
    end else if (advance) begin
      pc   <= atLast ? '0 : pc + ADDR_WIDTH'(1);
      wrap <= atLast;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: addresses the program ROM, registers the opcode
// and hands it to execute over valid/ready, honouring SNZ skips and restart.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int PROG_LEN    = 32,
  parameter int INSTR_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          restart,
  instr_fetch_if.master bus
);

  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = INSTR_WIDTH'(OP_NOP);

  fetch_state_t           state, stateNext;
  logic [INSTR_WIDTH-1:0] instrReg, instrNext;
  logic                   validReg, validNext;
  logic                   pcClear, pcAdvance;
  logic                   handshake;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   pcWrap;

  pc_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PROG_LEN   (PROG_LEN)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pcClear),
    .advance (pcAdvance),
    .pc      (pc),
    .wrap    (pcWrap)
  );

  assign handshake      = validReg & bus.instrReady;
  assign bus.addressOut = pc;
  assign bus.instrOut   = instrReg;
  assign bus.instrValid = validReg;
  assign bus.progWrap   = pcWrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      instrReg <= INSTR_NOP;
      validReg <= 1'b0;
    end else begin
      state    <= stateNext;
      instrReg <= instrNext;
      validReg <= validNext;
    end
  end

  always_comb begin
    stateNext = state;
    instrNext = instrReg;
    validNext = validReg;
    pcClear   = 1'b0;
    pcAdvance = 1'b0;

    if (restart) begin
      pcClear   = 1'b1;
      validNext = 1'b0;
      instrNext = INSTR_NOP;
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          validNext = 1'b0;
          if (en) stateNext = FETCH;
        end
        FETCH: begin
          instrNext = bus.dataIn;
          pcAdvance = 1'b1;
          validNext = 1'b1;
          stateNext = HOLD;
        end
        HOLD: begin
          // Without a handshake everything stays frozen, skipReq and en included
          if (handshake) begin
            if (bus.skipReq) begin
              pcAdvance = 1'b1;
              validNext = 1'b0;
              stateNext = en ? FETCH : IDLE;
            end else if (en) begin
              instrNext = bus.dataIn;
              pcAdvance = 1'b1;
            end else begin
              validNext = 1'b0;
              stateNext = IDLE;
            end
          end
        end
        default: begin
          validNext = 1'b0;
          stateNext = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written reset/wrap/skip
// sequences, then random traffic compared against a rule-level reference model.
module tb_instr_fetch;

  localparam int ADDR_WIDTH  = 8;
  localparam int PROG_LEN    = 32;
  localparam int INSTR_WIDTH = 4;

  typedef struct {
    logic                   en;
    logic                   restart;
    logic                   ready;
    logic                   skip;
    logic                   expValid;
    logic [INSTR_WIDTH-1:0] expInstr;
    logic [ADDR_WIDTH-1:0]  expAddr;
    logic                   expWrap;
  } vec_t;

  logic clk;
  logic rst_n;
  logic en;
  logic restart;

  logic [INSTR_WIDTH-1:0] rom [0:(1<<ADDR_WIDTH)-1];

  int checks = 0;
  int errors = 0;

  int                     mPc;
  logic                   mValid;
  logic [INSTR_WIDTH-1:0] mInstr;
  logic                   mWrap;
  logic                   mFetchPending;

  vec_t vecs[$];

  instr_fetch_if #(.ADDR_WIDTH(ADDR_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) bus ();

  instr_fetch #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PROG_LEN    (PROG_LEN),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .restart (restart),
    .bus     (bus)
  );

  assign bus.dataIn = rom[bus.addressOut];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelReset();
    mPc           = 0;
    mValid        = 1'b0;
    mInstr        = 4'b0111;
    mWrap         = 1'b0;
    mFetchPending = 1'b0;
  endfunction

  function automatic void modelAdvance();
    mWrap = (mPc == PROG_LEN - 1);
    mPc   = (mPc + 1) % PROG_LEN;
  endfunction

  // One clock of the fetch rules, applied to the inputs seen at that edge
  function automatic void modelStep(input logic e, input logic r, input logic rd, input logic s);
    mWrap = 1'b0;
    if (r) begin
      mPc           = 0;
      mValid        = 1'b0;
      mInstr        = 4'b0111;
      mFetchPending = 1'b0;
    end else if (mFetchPending) begin
      mInstr        = rom[mPc];
      modelAdvance();
      mValid        = 1'b1;
      mFetchPending = 1'b0;
    end else if (mValid) begin
      if (rd) begin
        if (s) begin
          modelAdvance();
          mValid        = 1'b0;
          mFetchPending = e;
        end else if (e) begin
          mInstr = rom[mPc];
          modelAdvance();
        end else begin
          mValid = 1'b0;
        end
      end
    end else begin
      mFetchPending = e;
    end
  endfunction

  task automatic applyStimulus(input logic e, input logic r, input logic rd, input logic s);
    @(negedge clk);
    en             = e;
    restart        = r;
    bus.instrReady = rd;
    bus.skipReq    = s;
    @(posedge clk);
    modelStep(e, r, rd, s);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".addr"},  32'(bus.addressOut), 32'(mPc));
    checkOutput({tag, ".instr"}, 32'(bus.instrOut),   32'(mInstr));
    checkOutput({tag, ".valid"}, 32'(bus.instrValid), 32'(mValid));
    checkOutput({tag, ".wrap"},  32'(bus.progWrap),   32'(mWrap));
  endtask

  task automatic addVec(input logic e, input logic r, input logic rd, input logic s,
                        input logic v, input logic [3:0] i, input logic [7:0] a);
    vecs.push_back('{e, r, rd, s, v, i, a, 1'b0});
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    en             = 1'b0;
    restart        = 1'b0;
    bus.instrReady = 1'b0;
    bus.skipReq    = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkModel("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) rom[i] = 4'(i % 10);
    rom[0]  = 4'b0000;
    rom[1]  = 4'b0001;
    rom[2]  = 4'b0100;
    rom[3]  = 4'b0110;
    rom[4]  = 4'b1000;
    rom[5]  = 4'b0010;
    rom[6]  = 4'b0011;
    rom[31] = 4'b0111;

    // en, restart, ready, skip -> valid, instr, addr
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 8'd0);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 8'd1);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 8'd2);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h4, 8'd3);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 8'd3);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 8'd3);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 8'd3);
    addVec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h4, 8'd3);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 8'd3);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 8'd4);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h8, 8'd5);
    addVec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h8, 8'd6);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 8'd7);
    addVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 8'd7);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 8'd7);
    addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 8'd0);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 8'd0);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'd1);
    addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 8'd0);

    doReset();

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].en, vecs[k].restart, vecs[k].ready, vecs[k].skip);
      checkOutput($sformatf("vec%0d.valid", k), 32'(bus.instrValid), 32'(vecs[k].expValid));
      checkOutput($sformatf("vec%0d.instr", k), 32'(bus.instrOut),   32'(vecs[k].expInstr));
      checkOutput($sformatf("vec%0d.addr", k),  32'(bus.addressOut), 32'(vecs[k].expAddr));
      checkOutput($sformatf("vec%0d.wrap", k),  32'(bus.progWrap),   32'(vecs[k].expWrap));
    end

    // Asynchronous reset in the middle of streaming
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRst.addr",  32'(bus.addressOut), 32'd0);
    checkOutput("asyncRst.instr", 32'(bus.instrOut),   32'h7);
    checkOutput("asyncRst.valid", 32'(bus.instrValid), 32'd0);
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("postRst.valid", 32'(bus.instrValid), 32'd1);
    checkOutput("postRst.instr", 32'(bus.instrOut),   32'(rom[0]));
    checkModel("postRst");

    // Stream up to the last address, then across the wrap
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        reached = (mPc == PROG_LEN - 1) && mValid;
      end
      checkOutput("wrap.reachLast", 32'(reached), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("wrap.addr",  32'(bus.addressOut), 32'd0);
      checkOutput("wrap.pulse", 32'(bus.progWrap),   32'd1);
      checkOutput("wrap.instr", 32'(bus.instrOut),   32'h7);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("wrap.pulseEnd", 32'(bus.progWrap), 32'd0);
      checkOutput("wrap.instr0",   32'(bus.instrOut), 32'(rom[0]));
      checkOutput("wrap.addr1",    32'(bus.addressOut), 32'd1);

      reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        reached = (mPc == PROG_LEN - 1) && mValid;
      end
      checkOutput("skipWrap.reachLast", 32'(reached), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("skipWrap.addr",  32'(bus.addressOut), 32'd0);
      checkOutput("skipWrap.pulse", 32'(bus.progWrap),   32'd1);
      checkOutput("skipWrap.valid", 32'(bus.instrValid), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("skipWrap.valid2", 32'(bus.instrValid), 32'd1);
      checkOutput("skipWrap.instr",  32'(bus.instrOut),   32'(rom[0]));
      checkOutput("skipWrap.pulseEnd", 32'(bus.progWrap), 32'd0);
    end

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom % 8) != 0, ($urandom % 64) == 0,
                    ($urandom % 4) != 0, ($urandom % 4) == 0);
      checkModel($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
